// File: rtl/mac_array_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : mac_array_ctrl
// Description : Job sequencer for a chain of mac_col columns. Streams
//               LOAD_LEN key vectors from memory into the array, then issues
//               n_query query reads (throttled by the output FIFO), waits for
//               every query result to leave the last column, and pulses done.
//
// Ports
//   clk           rising-edge clock
//   reset         asynchronous active-low reset
//   start         job request, only sampled while idle
//   abort         synchronous job cancel (LOAD/GAP/EXEC/DRAIN)
//   k_base        first key address (captured on accepted start)
//   q_base        first query address (captured on accepted start)
//   n_query       query vectors per job (captured on accepted start)
//   ofifo_full    output FIFO full, stalls query issue
//   fifo_wr_last  one pulse per query finished by the last column
//   mem_rd_en     memory read strobe
//   mem_addr      memory read address
//   inst          column-0 instruction: [1] execute, [0] load
//   cnt_q         load counter broadcast to all columns
//   busy          high whenever a job is in progress
//   done          one-cycle job completion pulse
//
// Revision    : 1.0 - initial release
// ============================================================================
module mac_array_ctrl #(
    parameter int col      = 8,
    parameter int addr_bw  = 8,
    parameter int LOAD_LEN = 2 * col
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic               abort,
    input  logic [addr_bw-1:0] k_base,
    input  logic [addr_bw-1:0] q_base,
    input  logic [7:0]         n_query,
    input  logic               ofifo_full,
    input  logic               fifo_wr_last,
    output logic               mem_rd_en,
    output logic [addr_bw-1:0] mem_addr,
    output logic [1:0]         inst,
    output logic [7:0]         cnt_q,
    output logic               busy,
    output logic               done
);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_LOAD  = 3'd1;
    localparam logic [2:0] S_GAP   = 3'd2;
    localparam logic [2:0] S_EXEC  = 3'd3;
    localparam logic [2:0] S_DRAIN = 3'd4;
    localparam logic [2:0] S_FIN   = 3'd5;

    localparam logic [7:0] LOAD_LAST = 8'(LOAD_LEN - 1);

    logic [2:0]         state_q, state_d;
    logic [addr_bw-1:0] k_base_q;
    logic [addr_bw-1:0] q_base_q;
    logic [7:0]         n_query_q;
    logic [7:0]         ld_idx_q;
    logic [7:0]         qry_idx_q;
    logic [7:0]         cmp_cnt_q, cmp_cnt_d;
    logic [1:0]         inst_q;

    logic               ld_rd;
    logic               ex_rd;
    logic               cmp_inc;
    logic               abort_hit;

    // Abort only matters while a job is actually running; FIN is allowed to
    // complete so a done pulse is never half-delivered.
    assign abort_hit = abort && ((state_q == S_LOAD) || (state_q == S_GAP) ||
                                 (state_q == S_EXEC) || (state_q == S_DRAIN));

    // Results leaving the array only belong to this job once queries issue.
    assign cmp_inc   = fifo_wr_last && ((state_q == S_EXEC) || (state_q == S_DRAIN));
    assign cmp_cnt_d = cmp_cnt_q + {7'd0, cmp_inc};

    always_comb begin
        state_d = state_q;
        ld_rd   = 1'b0;
        ex_rd   = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_LOAD;
                end
            end
            S_LOAD: begin
                ld_rd = 1'b1;
                if (ld_idx_q == LOAD_LAST) begin
                    state_d = S_GAP;
                end
            end
            S_GAP: begin
                state_d = (n_query_q != 8'd0) ? S_EXEC : S_FIN;
            end
            S_EXEC: begin
                if (!ofifo_full) begin
                    ex_rd = 1'b1;
                    if ((qry_idx_q + 8'd1) == n_query_q) begin
                        state_d = S_DRAIN;
                    end
                end
            end
            S_DRAIN: begin
                // Uses the count including this cycle's pulse so done follows
                // the final result by one cycle; DRAIN is always visited once.
                if (cmp_cnt_d == n_query_q) begin
                    state_d = S_FIN;
                end
            end
            S_FIN: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // A read in the abort cycle would leave a dangling instruction in the
        // array, so the strobe is suppressed along with the state change.
        if (abort_hit) begin
            state_d = S_IDLE;
            ld_rd   = 1'b0;
            ex_rd   = 1'b0;
        end
    end

    always_comb begin
        mem_addr = '0;
        if (ld_rd) begin
            mem_addr = k_base_q + addr_bw'(ld_idx_q);
        end else if (ex_rd) begin
            mem_addr = q_base_q + addr_bw'(qry_idx_q);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= S_IDLE;
            k_base_q  <= '0;
            q_base_q  <= '0;
            n_query_q <= '0;
            ld_idx_q  <= '0;
            qry_idx_q <= '0;
            cmp_cnt_q <= '0;
            cnt_q     <= '0;
            inst_q    <= 2'b00;
        end else begin
            state_q <= state_d;
            // Memory data arrives one cycle after the read; the instruction is
            // delayed by the same amount so it travels with its data.
            inst_q  <= {ex_rd, ld_rd};
            if (abort_hit) begin
                ld_idx_q  <= '0;
                qry_idx_q <= '0;
                cmp_cnt_q <= '0;
                cnt_q     <= '0;
            end else if ((state_q == S_IDLE) && start) begin
                k_base_q  <= k_base;
                q_base_q  <= q_base;
                n_query_q <= n_query;
                ld_idx_q  <= '0;
                qry_idx_q <= '0;
                cmp_cnt_q <= '0;
                cnt_q     <= '0;
            end else begin
                if (ld_rd) begin
                    ld_idx_q <= ld_idx_q + 8'd1;
                    // Advanced with the read so it reads 1 in the first cycle
                    // the load instruction is visible.
                    cnt_q    <= cnt_q + 8'd1;
                end
                if (ex_rd) begin
                    qry_idx_q <= qry_idx_q + 8'd1;
                end
                cmp_cnt_q <= cmp_cnt_d;
            end
        end
    end

    assign mem_rd_en = ld_rd | ex_rd;
    assign inst      = inst_q;
    assign busy      = (state_q != S_IDLE);
    assign done      = (state_q == S_FIN);

endmodule
`default_nettype wire

// File: tb/tb_mac_array_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_mac_array_ctrl
// Description : Directed self-checking bench for mac_array_ctrl.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mac_array_ctrl;

    logic       clk = 1'b0;
    logic       reset;
    logic       start;
    logic       abort;
    logic [7:0] k_base;
    logic [7:0] q_base;
    logic [7:0] n_query;
    logic       ofifo_full;
    logic       fifo_wr_last;
    logic       mem_rd_en;
    logic [7:0] mem_addr;
    logic [1:0] inst;
    logic [7:0] cnt_q;
    logic       busy;
    logic       done;

    int n_chk  = 0;
    int n_fail = 0;

    mac_array_ctrl #(.col(8), .addr_bw(8), .LOAD_LEN(16)) dut (
        .clk          (clk),
        .reset        (reset),
        .start        (start),
        .abort        (abort),
        .k_base       (k_base),
        .q_base       (q_base),
        .n_query      (n_query),
        .ofifo_full   (ofifo_full),
        .fifo_wr_last (fifo_wr_last),
        .mem_rd_en    (mem_rd_en),
        .mem_addr     (mem_addr),
        .inst         (inst),
        .cnt_q        (cnt_q),
        .busy         (busy),
        .done         (done)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b0; start = 1'b0; abort = 1'b0;
        k_base = 8'h0; q_base = 8'h0; n_query = 8'h0;
        ofifo_full = 1'b0; fifo_wr_last = 1'b0;
        #2;
        n_chk++;
        if ({mem_rd_en, mem_addr, inst, cnt_q, busy, done} !== 21'd0) begin
            n_fail++;
            $display("FAIL reset_outputs: got rd=%b addr=%h inst=%b cnt=%0d busy=%b done=%b want all 0",
                     mem_rd_en, mem_addr, inst, cnt_q, busy, done);
        end
        tick(); tick();
        reset = 1'b1;
        tick();
    endtask

    // k=0x10 q=0x40 n=3, no stall; start held high into LOAD with a different
    // k_base must not re-capture.
    task automatic test_basic();
        start = 1'b1; k_base = 8'h10; q_base = 8'h40; n_query = 8'd3;
        #1;
        n_chk++;
        if (busy !== 1'b0) begin n_fail++; $display("FAIL basic_idle_busy: got %b want 0", busy); end
        tick();
        for (int i = 0; i < 16; i++) begin
            if (i == 0) k_base = 8'h99;
            if (i == 3) start = 1'b0;
            #1;
            n_chk++;
            if (mem_rd_en !== 1'b1 || mem_addr !== 8'(8'h10 + i) ||
                inst !== ((i == 0) ? 2'b00 : 2'b01) || cnt_q !== 8'(i) || busy !== 1'b1) begin
                n_fail++;
                $display("FAIL basic_load[%0d]: got rd=%b addr=%h inst=%b cnt=%0d busy=%b want rd=1 addr=%h inst=%b cnt=%0d busy=1",
                         i, mem_rd_en, mem_addr, inst, cnt_q, busy, 8'(8'h10 + i), (i == 0) ? 2'b00 : 2'b01, i);
            end
            tick();
        end
        n_chk++;
        if (mem_rd_en !== 1'b0 || inst !== 2'b01 || cnt_q !== 8'd16) begin
            n_fail++;
            $display("FAIL basic_gap: got rd=%b inst=%b cnt=%0d want rd=0 inst=01 cnt=16", mem_rd_en, inst, cnt_q);
        end
        tick();
        for (int j = 0; j < 3; j++) begin
            n_chk++;
            if (mem_rd_en !== 1'b1 || mem_addr !== 8'(8'h40 + j) || inst !== ((j == 0) ? 2'b00 : 2'b10)) begin
                n_fail++;
                $display("FAIL basic_exec[%0d]: got rd=%b addr=%h inst=%b want rd=1 addr=%h inst=%b",
                         j, mem_rd_en, mem_addr, inst, 8'(8'h40 + j), (j == 0) ? 2'b00 : 2'b10);
            end
            tick();
        end
        n_chk++;
        if (mem_rd_en !== 1'b0 || inst !== 2'b10 || done !== 1'b0) begin
            n_fail++;
            $display("FAIL basic_drain_entry: got rd=%b inst=%b done=%b want rd=0 inst=10 done=0", mem_rd_en, inst, done);
        end
        fifo_wr_last = 1'b1; tick();
        fifo_wr_last = 1'b0; #1;
        n_chk++;
        if (done !== 1'b0) begin n_fail++; $display("FAIL basic_done_early1: got %b want 0", done); end
        tick();
        fifo_wr_last = 1'b1; tick();
        #1;
        n_chk++;
        if (done !== 1'b0 || inst !== 2'b00) begin
            n_fail++;
            $display("FAIL basic_done_early2: got done=%b inst=%b want done=0 inst=00", done, inst);
        end
        tick();
        fifo_wr_last = 1'b0; #1;
        n_chk++;
        if (done !== 1'b1 || busy !== 1'b1 || inst !== 2'b00) begin
            n_fail++;
            $display("FAIL basic_done: got done=%b busy=%b inst=%b want done=1 busy=1 inst=00", done, busy, inst);
        end
        tick();
        n_chk++;
        if (done !== 1'b0 || busy !== 1'b0 || cnt_q !== 8'd16) begin
            n_fail++;
            $display("FAIL basic_after_done: got done=%b busy=%b cnt=%0d want done=0 busy=0 cnt=16", done, busy, cnt_q);
        end
    endtask

    task automatic test_zero_query();
        int at;
        int rds;
        logic ex;
        at = 0; rds = 0; ex = 1'b0;
        start = 1'b1; k_base = 8'h20; q_base = 8'h00; n_query = 8'd0;
        tick();
        start = 1'b0;
        for (int k = 1; k <= 40; k++) begin
            if (inst[1]) ex = 1'b1;
            if (mem_rd_en) rds++;
            if (done) begin at = k; break; end
            tick();
        end
        n_chk++;
        if (at !== 18) begin n_fail++; $display("FAIL zero_done_latency: got %0d want 18", at); end
        n_chk++;
        if (rds !== 16 || ex !== 1'b0) begin
            n_fail++;
            $display("FAIL zero_reads: got reads=%0d exec_seen=%b want reads=16 exec_seen=0", rds, ex);
        end
        tick();
        n_chk++;
        if (busy !== 1'b0) begin n_fail++; $display("FAIL zero_idle: got busy=%b want 0", busy); end
    endtask

    // n=4, FIFO full for two cycles after the 2nd query read; result pulses
    // during LOAD/GAP must not count toward completion.
    task automatic test_stall();
        logic fl   [6] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
        logic rd_e [6] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
        logic [1:0] in_e [6] = '{2'b00, 2'b10, 2'b10, 2'b00, 2'b00, 2'b10};
        logic [7:0] ad_e [6] = '{8'h80, 8'h81, 8'h00, 8'h00, 8'h82, 8'h83};
        start = 1'b1; k_base = 8'h00; q_base = 8'h80; n_query = 8'd4;
        tick();
        start = 1'b0; fifo_wr_last = 1'b1;
        repeat (17) tick();
        fifo_wr_last = 1'b0;
        for (int k = 0; k < 6; k++) begin
            ofifo_full = fl[k];
            #1;
            n_chk++;
            if (mem_rd_en !== rd_e[k] || inst !== in_e[k] || (rd_e[k] && mem_addr !== ad_e[k])) begin
                n_fail++;
                $display("FAIL stall_exec[%0d]: got rd=%b addr=%h inst=%b want rd=%b addr=%h inst=%b",
                         k, mem_rd_en, mem_addr, inst, rd_e[k], ad_e[k], in_e[k]);
            end
            tick();
        end
        ofifo_full = 1'b0;
        n_chk++;
        if (mem_rd_en !== 1'b0 || inst !== 2'b10) begin
            n_fail++;
            $display("FAIL stall_drain: got rd=%b inst=%b want rd=0 inst=10", mem_rd_en, inst);
        end
        for (int p = 0; p < 4; p++) begin
            fifo_wr_last = 1'b1;
            #1;
            n_chk++;
            if (done !== 1'b0) begin n_fail++; $display("FAIL stall_done_early[%0d]: got %b want 0", p, done); end
            tick();
        end
        fifo_wr_last = 1'b0;
        #1;
        n_chk++;
        if (done !== 1'b1) begin n_fail++; $display("FAIL stall_done: got %b want 1", done); end
        tick();
    endtask

    task automatic test_wrap();
        logic [7:0] ea;
        logic seen;
        seen = 1'b0;
        start = 1'b1; k_base = 8'hF8; q_base = 8'h00; n_query = 8'd0;
        tick();
        start = 1'b0;
        for (int i = 0; i < 16; i++) begin
            ea = 8'hF8 + 8'(i);
            n_chk++;
            if (mem_rd_en !== 1'b1 || mem_addr !== ea) begin
                n_fail++;
                $display("FAIL wrap_addr[%0d]: got rd=%b addr=%h want rd=1 addr=%h", i, mem_rd_en, mem_addr, ea);
            end
            tick();
        end
        for (int k = 0; k < 10; k++) begin
            if (done) begin seen = 1'b1; break; end
            tick();
        end
        n_chk++;
        if (seen !== 1'b1) begin n_fail++; $display("FAIL wrap_done_timeout: got done_seen=%b want 1", seen); end
        tick();
    endtask

    task automatic test_abort();
        int at;
        int rds;
        logic dn;
        at = 0; rds = 0; dn = 1'b0;
        start = 1'b1; k_base = 8'h30; q_base = 8'h50; n_query = 8'd8;
        tick();
        start = 1'b0;
        repeat (17) tick();
        repeat (4) tick();
        n_chk++;
        if (mem_rd_en !== 1'b1 || mem_addr !== 8'h54) begin
            n_fail++;
            $display("FAIL abort_pre: got rd=%b addr=%h want rd=1 addr=54", mem_rd_en, mem_addr);
        end
        abort = 1'b1;
        tick();
        abort = 1'b0;
        #1;
        n_chk++;
        if (busy !== 1'b0 || mem_rd_en !== 1'b0 || inst !== 2'b00 || cnt_q !== 8'd0 || done !== 1'b0) begin
            n_fail++;
            $display("FAIL abort_idle: got busy=%b rd=%b inst=%b cnt=%0d done=%b want 0 0 00 0 0",
                     busy, mem_rd_en, inst, cnt_q, done);
        end
        fifo_wr_last = 1'b1;
        repeat (3) begin
            tick();
            if (done || busy) dn = 1'b1;
        end
        fifo_wr_last = 1'b0;
        n_chk++;
        if (dn !== 1'b0) begin n_fail++; $display("FAIL abort_stray: got activity=%b want 0", dn); end
        start = 1'b1; k_base = 8'h30; q_base = 8'h20; n_query = 8'd1;
        tick();
        start = 1'b0;
        for (int k = 1; k <= 60; k++) begin
            fifo_wr_last = inst[1];
            #1;
            if (mem_rd_en) rds++;
            if (done) begin at = k; break; end
            tick();
        end
        fifo_wr_last = 1'b0;
        n_chk++;
        if (at !== 20 || rds !== 17) begin
            n_fail++;
            $display("FAIL abort_rerun: got done_at=%0d reads=%0d want done_at=20 reads=17", at, rds);
        end
        tick();
    endtask

    task automatic test_reset_mid();
        logic dn;
        logic seen;
        dn = 1'b0; seen = 1'b0;
        start = 1'b1; k_base = 8'h00; q_base = 8'h60; n_query = 8'd2;
        tick();
        start = 1'b0;
        repeat (17) tick();
        tick(); tick();
        n_chk++;
        if (busy !== 1'b1 || inst !== 2'b10 || mem_rd_en !== 1'b0) begin
            n_fail++;
            $display("FAIL rstmid_drain: got busy=%b inst=%b rd=%b want 1 10 0", busy, inst, mem_rd_en);
        end
        reset = 1'b0;
        #1;
        n_chk++;
        if ({mem_rd_en, mem_addr, inst, cnt_q, busy, done} !== 21'd0) begin
            n_fail++;
            $display("FAIL rstmid_async: got rd=%b addr=%h inst=%b cnt=%0d busy=%b done=%b want all 0",
                     mem_rd_en, mem_addr, inst, cnt_q, busy, done);
        end
        tick();
        reset = 1'b1;
        fifo_wr_last = 1'b1;
        repeat (3) begin
            tick();
            if (done || busy) dn = 1'b1;
        end
        fifo_wr_last = 1'b0;
        n_chk++;
        if (dn !== 1'b0) begin n_fail++; $display("FAIL rstmid_stray: got activity=%b want 0", dn); end
        reset = 1'b0;
        tick();
        reset = 1'b1;
        start = 1'b1; k_base = 8'h00; q_base = 8'h00; n_query = 8'd0;
        tick();
        start = 1'b0;
        n_chk++;
        if (busy !== 1'b1 || mem_rd_en !== 1'b1 || mem_addr !== 8'h00) begin
            n_fail++;
            $display("FAIL rstmid_first_start: got busy=%b rd=%b addr=%h want 1 1 00", busy, mem_rd_en, mem_addr);
        end
        for (int k = 0; k < 30; k++) begin
            if (done) begin seen = 1'b1; break; end
            tick();
        end
        n_chk++;
        if (seen !== 1'b1) begin n_fail++; $display("FAIL rstmid_job_timeout: got done_seen=%b want 1", seen); end
        tick();
    endtask

    initial begin
        test_reset();
        test_basic();
        test_zero_query();
        test_stall();
        test_wrap();
        test_abort();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, checks=%0d failures=%0d", n_chk, n_fail);
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
